core8_cpu_debug_ocimem: RTL and testbench
=========================================

// Module: core8_cpu_debug_ocimem
// PURPOSE
//  Debug-memory stage downstream of the JTAG debug-module wrapper. Consumes its jdo bus and
//  take_*_ocimem_* strobes (clk domain), performs JTAG reads/writes of a private debug RAM,
//  and returns MonDReg/monitor_ready/monitor_error to the wrapper's tck side. A CPU-side
//  Avalon-MM slave shares the RAM port; JTAG has priority, CPU is held with waitrequest.
// PARAMETERS
//  ADDR_W   8   word-address width of debug RAM (depth 2**ADDR_W x 32b); legal 4..16
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       asynchronous, active-low reset
//  jdo                      in   38      JTAG data, synchronised to clk
//  take_action_ocimem_a     in   1       1-cycle strobe: load address (optional read)
//  take_no_action_ocimem_a  in   1       1-cycle strobe: increment address then read
//  take_action_ocimem_b     in   1       1-cycle strobe: write data at address, then increment
//  MonDReg                  out  32      JTAG read-data register
//  MonAReg                  out  ADDR_W  current JTAG word address
//  monitor_ready            out  1       last JTAG command complete
//  monitor_error            out  1       sticky: command dropped (overrun/collision)
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1       CPU request (never both set)
//  avs_writedata            in   32      CPU write data
//  avs_byteenable           in   4       CPU byte lanes
//  avs_readdata             out  32      CPU read data
//  avs_readdatavalid        out  1       avs_readdata valid this cycle
//  avs_waitrequest          out  1       CPU request not accepted this cycle
// BEHAVIOUR
//  Reset: MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0,
//   avs_readdatavalid=0, FSM=IDLE. RAM contents are not reset.
//  Field map: addr=jdo[17+:ADDR_W]; rd flag=jdo[34] (ocimem_a only); wdata=jdo[34:3].
//  FSM: IDLE -> J_ISSUE on any accepted strobe; J_ISSUE -> J_CAPT (read) or IDLE (write/
//   address-only); J_CAPT -> IDLE. A strobe is accepted only in IDLE.
//  Strobe at cycle T, accepted: monitor_ready cleared at end of T; command latched.
//   ocimem_a: MonAReg<=addr at end of T; rd=0 -> monitor_ready=1 from T+2; rd=1 -> RAM read
//    issued in T+1, MonDReg and monitor_ready=1 visible from T+3.
//   no_action_a: MonAReg<=MonAReg+1 at end of T, then read as above (visible T+3).
//   ocimem_b: RAM[MonAReg]<=wdata (all 32 bits) at end of T+1; MonAReg<=MonAReg+1 and
//    monitor_ready=1 from T+2.
//  MonAReg increments modulo 2**ADDR_W (max -> 0), no error.
//  Strobe outside IDLE: ignored (MonAReg/MonDReg unchanged), monitor_error<=1.
//  >1 strobe in one cycle: priority ocimem_a > no_action_a > ocimem_b; the winner executes,
//   monitor_error<=1. monitor_error clears only on an accepted ocimem_a with rd=0.
//  avs_waitrequest = (FSM!=IDLE) | any strobe this cycle (combinational).
//  CPU read accepted in C (avs_read & !waitrequest): avs_readdata/avs_readdatavalid=1 in C+1,
//   valid for exactly one cycle. CPU write accepted in C: byte lanes per avs_byteenable
//   written at end of C. Read-after-write to same address in C+1 returns new data.
//  RAM: single port, 1-cycle synchronous read; exactly one access per cycle.
//  Reset mid-operation: FSM->IDLE, pending command and readdatavalid discarded.
// TESTING
//  1 ocimem_b x3 (jdo wdata 0xDEADBEEF,1,2) after ocimem_a addr=0x10 rd=0 -> RAM[0x10..0x12]
//    written, MonAReg=0x13, monitor_ready=1 at T+2 of each.
//  2 ocimem_a addr=0x10 rd=1 then no_action_a -> MonDReg=0xDEADBEEF at T+3, then 0x00000001;
//    MonAReg=0x11.
//  3 ocimem_a addr=0xFF rd=0, no_action_a (ADDR_W=8) -> MonAReg wraps to 0x00, reads RAM[0].
//  4 CPU write 0x11223344 be=4'b0101 to 0x20 over 0xAABBCCDD, read back -> 0xAA22CC44
//    with readdatavalid one cycle after accept.
//  5 CPU read held during JTAG strobe -> waitrequest=1 through J_ISSUE/J_CAPT; accepted on
//    return to IDLE; JTAG result unaffected.
//  6 no_action_a at T+1 after ocimem_a rd=1 -> ignored, monitor_error=1; reset_n low mid-read
//    -> all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/core8_cpu_debug_ocimem.sv
// Debug-memory stage: JTAG-driven reads/writes of a private 32-bit debug RAM,
// with a CPU Avalon-MM slave sharing the single RAM port (JTAG has priority).
module core8_cpu_debug_ocimem #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [31:0]       MonDReg,
   output logic [ADDR_W-1:0] MonAReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_readdatavalid,
   output logic              avs_waitrequest,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, J_ISSUE = 2'd1, J_CAPT = 2'd2} state_e;

   state_e              state_q;
   logic [31:0]         mon_d_q;
   logic [ADDR_W-1:0]   mon_a_q;
   logic                ready_q;
   logic                error_q;
   logic                cmd_rd_q;
   logic                cmd_wr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic                rvalid_q;
   logic [31:0]         mem_q [2**ADDR_W];

   logic                any_strobe;
   logic                multi_strobe;
   logic                cpu_rd;
   logic                cpu_wr;
   logic [ADDR_W-1:0]   mem_addr;
   logic [31:0]         mem_wdata;
   logic [3:0]          mem_we;
   logic                mem_re;
   logic                unused_jdo;

   assign unused_jdo   = ^{jdo[37:35], jdo[2:0]};
   assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a) |
                         (take_action_ocimem_a & take_action_ocimem_b) |
                         (take_no_action_ocimem_a & take_action_ocimem_b);

   // Any strobe stalls the CPU in the same cycle so JTAG never loses the port.
   assign avs_waitrequest = (state_q != IDLE) | any_strobe;
   assign cpu_rd          = avs_read  & ~avs_waitrequest;
   assign cpu_wr          = avs_write & ~avs_waitrequest;

   always_comb begin
      mem_addr  = avs_address;
      mem_wdata = avs_writedata;
      mem_we    = 4'b0000;
      mem_re    = 1'b0;
      if (state_q == J_ISSUE) begin
         mem_addr  = mon_a_q;
         mem_wdata = wdata_q;
         mem_we    = {4{cmd_wr_q}};
         mem_re    = cmd_rd_q;
      end else if (cpu_wr) begin
         mem_we = avs_byteenable;
      end else if (cpu_rd) begin
         mem_re = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i]) mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         mon_d_q  <= '0;
         mon_a_q  <= '0;
         ready_q  <= 1'b0;
         error_q  <= 1'b0;
         cmd_rd_q <= 1'b0;
         cmd_wr_q <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= cpu_rd;
         if (mem_re) rdata_q <= mem_q[mem_addr];
         case (state_q)
            IDLE: begin
               if (any_strobe) begin
                  state_q <= J_ISSUE;
                  ready_q <= 1'b0;
                  if (multi_strobe) error_q <= 1'b1;
                  if (take_action_ocimem_a) begin
                     mon_a_q  <= jdo[17 +: ADDR_W];
                     cmd_rd_q <= jdo[34];
                     cmd_wr_q <= 1'b0;
                     if (!jdo[34] && !multi_strobe) error_q <= 1'b0;
                  end else if (take_no_action_ocimem_a) begin
                     mon_a_q  <= mon_a_q + 1'b1;
                     cmd_rd_q <= 1'b1;
                     cmd_wr_q <= 1'b0;
                  end else begin
                     cmd_rd_q <= 1'b0;
                     cmd_wr_q <= 1'b1;
                     wdata_q  <= jdo[34:3];
                  end
               end
            end
            J_ISSUE: begin
               if (any_strobe) error_q <= 1'b1;
               if (cmd_rd_q) begin
                  state_q <= J_CAPT;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  if (cmd_wr_q) mon_a_q <= mon_a_q + 1'b1;
               end
            end
            J_CAPT: begin
               if (any_strobe) error_q <= 1'b1;
               mon_d_q <= rdata_q;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MonDReg           = mon_d_q;
   assign MonAReg           = mon_a_q;
   assign monitor_ready     = ready_q;
   assign monitor_error     = error_q;
   assign avs_readdata      = rdata_q;
   assign avs_readdatavalid = rvalid_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_core8_cpu_debug_ocimem.sv
// Directed bench for core8_cpu_debug_ocimem: JTAG read/write/wrap, CPU byte-lane
// writes, arbitration stalls, overrun error and mid-operation reset.
module tb_core8_cpu_debug_ocimem;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        sa = 1'b0, sna = 1'b0, sb = 1'b0;
   logic [31:0] MonDReg;
   logic [7:0]  MonAReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  avs_address = '0;
   logic        avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [3:0]  avs_byteenable = '0;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid, avs_waitrequest;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   core8_cpu_debug_ocimem #(.ADDR_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .jdo(jdo),
      .take_action_ocimem_a(sa), .take_no_action_ocimem_a(sna), .take_action_ocimem_b(sb),
      .MonDReg(MonDReg), .MonAReg(MonAReg),
      .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
      .avs_waitrequest(avs_waitrequest), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
      logic [37:0] d;
      d = '0;
      d[17 +: 8] = addr;
      d[34] = rd;
      return d;
   endfunction

   function automatic logic [37:0] jdo_b(input logic [31:0] wd);
      logic [37:0] d;
      d = '0;
      d[34:3] = wd;
      return d;
   endfunction

   // Drives strobes for one cycle (T); returns in cycle T+1.
   task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] d);
      jdo = d; sa = a; sna = na; sb = b;
      tick(1);
      sa = 1'b0; sna = 1'b0; sb = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
      int n;
      avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
      n = 0;
      #1;
      while (avs_waitrequest && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check("cpu_write_timeout", 32'd1, 32'd0);
      tick(1);
      avs_write = 1'b0;
   endtask

   // Returns in cycle C+1 with avs_readdata/valid checked there.
   task automatic cpu_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      int n;
      avs_address = addr; avs_read = 1'b1;
      n = 0;
      #1;
      while (avs_waitrequest && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check("cpu_read_timeout", 32'd1, 32'd0);
      tick(1);
      avs_read = 1'b0;
      check({tag, "_valid"}, {31'd0, avs_readdatavalid}, 32'd1);
      check({tag, "_data"}, avs_readdata, exp);
      tick(1);
      check({tag, "_valid_drop"}, {31'd0, avs_readdatavalid}, 32'd0);
   endtask

   initial begin
      tick(3);
      check("rst_mondreg", MonDReg, 32'd0);
      check("rst_monareg", {24'd0, MonAReg}, 32'd0);
      check("rst_ready", {31'd0, monitor_ready}, 32'd0);
      check("rst_error", {31'd0, monitor_error}, 32'd0);
      check("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      reset_n = 1'b1;
      tick(2);

      cpu_write(8'h00, 32'hCAFE0000, 4'b1111);

      // JTAG address load then three data writes
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0));
      check("t1_ready_clr", {31'd0, monitor_ready}, 32'd0);
      tick(1);
      check("t1_ready_set", {31'd0, monitor_ready}, 32'd1);
      check("t1_addr", {24'd0, MonAReg}, 32'h10);
      strobe(1'b0, 1'b0, 1'b1, jdo_b(32'hDEADBEEF));
      check("t1_w0_busy", {31'd0, monitor_ready}, 32'd0);
      tick(1);
      check("t1_w0_ready", {31'd0, monitor_ready}, 32'd1);
      check("t1_w0_addr", {24'd0, MonAReg}, 32'h11);
      strobe(1'b0, 1'b0, 1'b1, jdo_b(32'h00000001));
      tick(1);
      check("t1_w1_addr", {24'd0, MonAReg}, 32'h12);
      strobe(1'b0, 1'b0, 1'b1, jdo_b(32'h00000002));
      tick(1);
      check("t1_w2_ready", {31'd0, monitor_ready}, 32'd1);
      check("t1_w2_addr", {24'd0, MonAReg}, 32'h13);
      cpu_read("t1_ram12", 8'h12, 32'h00000002);

      // JTAG read and auto-increment read
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
      tick(1);
      check("t2_ready_t2", {31'd0, monitor_ready}, 32'd0);
      tick(1);
      check("t2_rd0_data", MonDReg, 32'hDEADBEEF);
      check("t2_rd0_ready", {31'd0, monitor_ready}, 32'd1);
      strobe(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0));
      tick(2);
      check("t2_rd1_data", MonDReg, 32'h00000001);
      check("t2_rd1_addr", {24'd0, MonAReg}, 32'h11);

      // Address wrap
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0));
      tick(1);
      strobe(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0));
      tick(2);
      check("t3_wrap_addr", {24'd0, MonAReg}, 32'h00);
      check("t3_wrap_data", MonDReg, 32'hCAFE0000);

      // CPU byte-lane write and read-after-write
      cpu_write(8'h20, 32'hAABBCCDD, 4'b1111);
      cpu_write(8'h20, 32'h11223344, 4'b0101);
      cpu_read("t4_rmw", 8'h20, 32'hAA22CC44);

      // CPU read stalled behind a JTAG read
      avs_address = 8'h20; avs_read = 1'b1;
      jdo = jdo_a(8'h10, 1'b1); sa = 1'b1;
      #1;
      check("t5_wait_strobe", {31'd0, avs_waitrequest}, 32'd1);
      tick(1);
      sa = 1'b0;
      #1;
      check("t5_wait_issue", {31'd0, avs_waitrequest}, 32'd1);
      tick(1);
      check("t5_wait_capt", {31'd0, avs_waitrequest}, 32'd1);
      check("t5_no_valid", {31'd0, avs_readdatavalid}, 32'd0);
      tick(1);
      check("t5_wait_idle", {31'd0, avs_waitrequest}, 32'd0);
      check("t5_jtag_data", MonDReg, 32'hDEADBEEF);
      tick(1);
      avs_read = 1'b0;
      check("t5_cpu_valid", {31'd0, avs_readdatavalid}, 32'd1);
      check("t5_cpu_data", avs_readdata, 32'hAA22CC44);
      tick(1);
      check("t5_valid_drop", {31'd0, avs_readdatavalid}, 32'd0);

      // Overrun: strobe while busy is dropped and flagged
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h11, 1'b1));
      strobe(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0));
      check("t6_err_set", {31'd0, monitor_error}, 32'd1);
      check("t6_addr_kept", {24'd0, MonAReg}, 32'h11);
      tick(1);
      check("t6_read_ok", MonDReg, 32'h00000001);
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h30, 1'b0));
      check("t6_err_clr", {31'd0, monitor_error}, 32'd0);
      tick(1);

      // Collision: ocimem_a wins over ocimem_b, error flagged
      strobe(1'b1, 1'b0, 1'b1, jdo_a(8'h40, 1'b0));
      tick(1);
      check("t6_coll_addr", {24'd0, MonAReg}, 32'h40);
      check("t6_coll_err", {31'd0, monitor_error}, 32'd1);

      // Reset in the middle of a JTAG read
      strobe(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1));
      reset_n = 1'b0;
      #1;
      check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
      check("t6_rst_mond", MonDReg, 32'd0);
      check("t6_rst_mona", {24'd0, MonAReg}, 32'd0);
      check("t6_rst_ready", {31'd0, monitor_ready}, 32'd0);
      check("t6_rst_error", {31'd0, monitor_error}, 32'd0);
      check("t6_rst_rdata", avs_readdata, 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(3);
      check("t6_post_ready", {31'd0, monitor_ready}, 32'd0);
      check("t6_post_state", {30'd0, dbg_state}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
